// File: rtl/interp_result_writer_if.sv
// Bundles the pixel-stream input, the result-SRAM write port and the status outputs
// of interp_result_writer. The environment drives through master; the writer uses slave.
interface interp_result_writer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
);
  logic              START;
  logic [DATA_W-1:0] I_DATA;
  logic              I_VALID;
  logic              W_READY;
  logic              WEN;
  logic [ADDR_W-1:0] W_ADDR;
  logic [DATA_W-1:0] W_DATA;
  logic              DONE;
  logic [15:0]       CHECKSUM;
  logic              OVERFLOW;

  modport master (
    output START, I_DATA, I_VALID, W_READY,
    input  WEN, W_ADDR, W_DATA, DONE, CHECKSUM, OVERFLOW
  );

  modport slave (
    input  START, I_DATA, I_VALID, W_READY,
    output WEN, W_ADDR, W_DATA, DONE, CHECKSUM, OVERFLOW
  );
endinterface

// File: rtl/interp_result_writer.sv
// Buffers the interpolated raster pixel stream in a small FIFO and writes it to the
// result SRAM, tracking a running checksum, a sticky overflow flag and frame completion.
module interp_result_writer #(
  parameter int DATA_W     = 8,
  parameter int OUT_W      = 17,
  parameter int OUT_H      = 17,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   RST_N,
  interp_result_writer_if.slave bus
);
  localparam int FRAME = OUT_W * OUT_H;
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [15:0]       checksum_q, checksum_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;

  logic              empty_s;
  logic              full_s;
  logic              active_s;
  logic              push_req_s;
  logic              pop_s;
  logic              push_ok_s;
  logic              frame_end_s;
  logic [DATA_W-1:0] head_s;

  // FIFO status and push/pop qualification; the extra pointer bit separates full from empty.
  always_comb begin
    empty_s     = (wr_ptr_q == rd_ptr_q);
    full_s      = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                  (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    active_s    = (state_q == RUN) || (state_q == DRAIN);
    head_s      = mem_q[rd_ptr_q[IDX_W-1:0]];
    push_req_s  = (state_q == RUN) && !bus.START && bus.I_VALID && (in_cnt_q < FRAME_CNT);
    pop_s       = active_s && !empty_s && bus.W_READY && !bus.START;
    push_ok_s   = push_req_s && (!full_s || pop_s);
    // All inputs taken and nothing left to write; also covers frames with dropped pixels.
    frame_end_s = (in_cnt_q == FRAME_CNT) && empty_s;
  end

  // Next-state logic for the FSM, FIFO, counters and status flags.
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    in_cnt_d   = in_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    checksum_d = checksum_q;
    overflow_d = overflow_q;
    done_d     = done_q;

    if (bus.START) begin
      state_d    = RUN;
      wr_ptr_d   = {PTR_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      in_cnt_d   = {CNT_W{1'b0}};
      wr_cnt_d   = {CNT_W{1'b0}};
      checksum_d = 16'h0000;
      overflow_d = 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_d[wr_ptr_q[IDX_W-1:0]] = bus.I_DATA;
        wr_ptr_d                   = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      in_cnt_d   = push_req_s ? (in_cnt_q + CNT_W'(1)) : in_cnt_q;
      overflow_d = overflow_q | (push_req_s & full_s & ~pop_s);

      if (pop_s) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        wr_cnt_d   = wr_cnt_q + CNT_W'(1);
        checksum_d = checksum_q + 16'(head_s);
      end else begin
        rd_ptr_d   = rd_ptr_q;
        wr_cnt_d   = wr_cnt_q;
        checksum_d = checksum_q;
      end

      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     state_d = frame_end_s ? FIN : ((in_cnt_q == FRAME_CNT) ? DRAIN : RUN);
        DRAIN:   state_d = frame_end_s ? FIN : DRAIN;
        FIN:     state_d = FIN;
        default: state_d = IDLE;
      endcase
    end

    done_d = (state_d == FIN);
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      in_cnt_q   <= {CNT_W{1'b0}};
      wr_cnt_q   <= {CNT_W{1'b0}};
      checksum_q <= 16'h0000;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_cnt_q   <= in_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      checksum_q <= checksum_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign bus.WEN      = ~(active_s & ~empty_s);
  assign bus.W_ADDR   = wr_cnt_q;
  assign bus.W_DATA   = empty_s ? {DATA_W{1'b0}} : head_s;
  assign bus.DONE     = done_q;
  assign bus.CHECKSUM = checksum_q;
  assign bus.OVERFLOW = overflow_q;
endmodule

// File: tb/tb_interp_result_writer.sv
// Bench for interp_result_writer: constant vector table, directed frame scenarios and
// random frames, all compared every cycle against a queue-based reference model.
module tb_interp_result_writer;
  localparam int FRAME = 289;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;

  interp_result_writer_if #(.DATA_W(8), .ADDR_W(9)) bus ();

  interp_result_writer #(
    .DATA_W(8), .OUT_W(17), .OUT_H(17), .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wen;
    logic [8:0] addr;
    logic [7:0] data;
    logic       done;
    logic [15:0] cks;
    logic       ovf;
  } outs_t;

  typedef struct {
    bit          st;
    bit          iv;
    logic [7:0]  d;
    bit          wr;
    logic        wen;
    logic [8:0]  addr;
    logic [7:0]  data;
    logic [15:0] cks;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: a plain queue of buffered pixels plus frame counters.
  bit          m_run, m_done, m_ovf;
  int          m_in, m_wr;
  logic [15:0] m_cks;
  logic [7:0]  m_q[$];

  int          wr_seen;
  logic [8:0]  last_addr;
  outs_t       rst_exp;
  vec_t        tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic outs_t dut_outs();
    return {bus.WEN, bus.W_ADDR, bus.W_DATA, bus.DONE, bus.CHECKSUM, bus.OVERFLOW};
  endfunction

  function automatic outs_t model_outs();
    outs_t o;
    o.wen  = !(m_run && m_q.size() > 0);
    o.addr = 9'(m_wr);
    o.data = (m_q.size() > 0) ? m_q[0] : 8'h00;
    o.done = m_done;
    o.cks  = m_cks;
    o.ovf  = m_ovf;
    return o;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_run  = 1'b0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
    m_in   = 0;
    m_wr   = 0;
    m_cks  = 16'h0000;
  endtask

  task automatic model_edge(input bit st, input bit iv, input logic [7:0] d, input bit wr);
    int sz;
    bit pop;
    bit fin;
    sz  = m_q.size();
    pop = (sz > 0) && wr;
    fin = (m_in == FRAME) && (sz == 0);
    if (st) begin
      model_reset();
      m_run = 1'b1;
    end else if (m_run) begin
      if (pop) begin
        m_cks = m_cks + 16'(m_q.pop_front());
        m_wr++;
      end
      if (iv && m_in < FRAME) begin
        m_in++;
        if (sz == DEPTH && !pop) m_ovf = 1'b1;
        else m_q.push_back(d);
      end
      if (fin) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic cycle(input bit st, input bit iv, input logic [7:0] d, input bit wr);
    bus.START   = st;
    bus.I_VALID = iv;
    bus.I_DATA  = d;
    bus.W_READY = wr;
    if (!bus.WEN && wr && !st) begin
      wr_seen++;
      last_addr = bus.W_ADDR;
    end
    @(posedge clk);
    model_edge(st, iv, d, wr);
    #1;
    chk("cycle_outputs", 64'(dut_outs()), 64'(model_outs()));
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (bus.DONE === 1'b1) break;
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk(name, 64'(bus.DONE), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int iv_pct [3];
    int wr_pct [3];
    logic [15:0] saved_cks;

    rst_exp     = '0;
    rst_exp.wen = 1'b1;

    rst_n       = 1'b0;
    bus.START   = 1'b0;
    bus.I_VALID = 1'b0;
    bus.I_DATA  = 8'h00;
    bus.W_READY = 1'b0;
    wr_seen     = 0;
    last_addr   = 9'd0;
    model_reset();
    #2;
    chk("reset_outputs", 64'(dut_outs()), 64'(rst_exp));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Short hand-derived sequence: idle input, START, two pushes under stall, drain.
    tbl[0] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 9'd0, 8'h00, 16'h0000};
    tbl[1] = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 9'd0, 8'h00, 16'h0000};
    tbl[2] = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 9'd0, 8'h05, 16'h0000};
    tbl[3] = '{1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 9'd0, 8'h05, 16'h0000};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'd1, 8'h07, 16'h0005};
    tbl[5] = '{1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 9'd2, 8'h10, 16'h000C};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 9'd3, 8'h00, 16'h001C};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 9'd3, 8'h00, 16'h001C};
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].st, tbl[i].iv, tbl[i].d, tbl[i].wr);
      chk($sformatf("table[%0d]", i),
          64'({bus.WEN, bus.W_ADDR, bus.W_DATA, bus.CHECKSUM}),
          64'({tbl[i].wen, tbl[i].addr, tbl[i].data, tbl[i].cks}));
    end

    // Nominal frame, then post-frame input that must be ignored.
    wr_seen = 0;
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < FRAME; i++) begin
      cycle(1'b0, 1'b1, 8'(i), 1'b1);
      if (i == 0) chk("nominal_first_wen_data", 64'({bus.WEN, bus.W_DATA}), 64'({1'b0, 8'h00}));
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("nominal_after_last_write", 64'({bus.WEN, bus.DONE, bus.W_ADDR}), 64'({1'b1, 1'b0, 9'd289}));
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("nominal_done_two_after", 64'(bus.DONE), 64'(1));
    chk("nominal_writes", 64'(wr_seen), 64'(289));
    chk("nominal_last_addr", 64'(last_addr), 64'(288));
    chk("nominal_checksum", 64'(bus.CHECKSUM), 64'(16'h8190));
    chk("nominal_overflow", 64'(bus.OVERFLOW), 64'(0));
    saved_cks = bus.CHECKSUM;
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 8'($urandom), 1'b1);
    chk("post_frame_checksum", 64'(bus.CHECKSUM), 64'(saved_cks));
    chk("post_frame_writes", 64'(wr_seen), 64'(289));
    chk("post_frame_wen_done", 64'({bus.WEN, bus.DONE}), 64'({1'b1, 1'b1}));

    // Backpressure within capacity followed by a push/pop at full.
    wr_seen = 0;
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 8'(i), 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 100; i < 104; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
    chk("bp_full_head", 64'({bus.WEN, bus.W_DATA, bus.W_ADDR}), 64'({1'b0, 8'd100, 9'd100}));
    cycle(1'b0, 1'b1, 8'd104, 1'b1);
    chk("full_boundary_no_drop", 64'({bus.OVERFLOW, bus.W_DATA}), 64'({1'b0, 8'd101}));
    for (int i = 105; i < FRAME; i++) cycle(1'b0, 1'b1, 8'(i), 1'b1);
    wait_done("bp_done", 20);
    chk("bp_writes", 64'(wr_seen), 64'(289));
    chk("bp_checksum", 64'(bus.CHECKSUM), 64'(16'h8190));
    chk("bp_overflow", 64'(bus.OVERFLOW), 64'(0));

    // Overflow: SRAM stalled for the first 10 input cycles, 6 pixels dropped.
    wr_seen = 0;
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < FRAME; i++) begin
      cycle(1'b0, 1'b1, 8'(i), (i >= 10));
      if (i == 3) chk("ovf_not_yet", 64'(bus.OVERFLOW), 64'(0));
      if (i == 4) chk("ovf_first_drop", 64'(bus.OVERFLOW), 64'(1));
    end
    wait_done("ovf_done", 20);
    chk("ovf_sticky", 64'(bus.OVERFLOW), 64'(1));
    chk("ovf_final_addr", 64'(bus.W_ADDR), 64'(283));
    chk("ovf_writes", 64'(wr_seen), 64'(283));

    // Restart after 100 pixels.
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 8'(i + 7), 1'b1);
    wr_seen = 0;
    cycle(1'b1, 1'b1, 8'hAA, 1'b1);
    chk("restart_cleared", 64'({bus.WEN, bus.W_ADDR, bus.CHECKSUM, bus.DONE}), 64'({1'b1, 9'd0, 16'h0000, 1'b0}));
    for (int i = 0; i < FRAME; i++) begin
      cycle(1'b0, 1'b1, 8'(i), 1'b1);
      if (i == 0) chk("restart_first_addr", 64'({bus.WEN, bus.W_ADDR}), 64'({1'b0, 9'd0}));
    end
    wait_done("restart_done", 20);
    chk("restart_writes", 64'(wr_seen), 64'(289));
    chk("restart_checksum", 64'(bus.CHECKSUM), 64'(16'h8190));

    // Asynchronous reset in the middle of a frame.
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_immediate", 64'(dut_outs()), 64'(rst_exp));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 8'h33, 1'b1);
    chk("idle_after_reset", 64'(dut_outs()), 64'(rst_exp));

    // Random frames with varying input density and SRAM readiness.
    iv_pct = '{70, 60, 95};
    wr_pct = '{70, 90, 50};
    for (int f = 0; f < 3; f++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      for (int k = 0; k < 3000 && !m_done; k++) begin
        cycle(1'b0, ($urandom_range(0, 99) < iv_pct[f]), 8'($urandom),
              ($urandom_range(0, 99) < wr_pct[f]));
      end
      chk($sformatf("random_frame%0d_done", f), 64'(bus.DONE), 64'(1));
    end

    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_after_done", 64'(dut_outs()), 64'(rst_exp));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/interp_result_writer.md
# interp_result_writer

Downstream stage of the interpolation engine. Captures the 17×17 raster-order pixel stream (O_DATA/O_VALID, 289 pixels per frame) into a small FIFO and writes it to the output result SRAM through a ready-qualified, active-low write port. Maintains a running checksum, a sticky overflow flag and a frame-done indication for the top-level controller.

## Interface
Parameters:
- DATA_W, 8: pixel width.
- OUT_W, 17: pixels per output row.
- OUT_H, 17: output rows; frame size is OUT_W*OUT_H = 289.
- FIFO_DEPTH, 4: FIFO entries, power of two.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- START  in  1  one-cycle frame-start pulse, shared with the interpolation engine.
- I_DATA  in  8  pixel from the interpolation engine.
- I_VALID  in  1  I_DATA valid this cycle; no backpressure toward the source.
- W_READY  in  1  SRAM accepts a write this cycle.
- WEN  out  1  write enable, active-low.
- W_ADDR  out  9  write address, row*17 + col, range 0..288.
- W_DATA  out  8  write data.
- DONE  out  1  level; frame fully written.
- CHECKSUM  out  16  sum of written pixels, mod 2^16.
- OVERFLOW  out  1  sticky; a pixel was dropped because the FIFO was full.

## Operation
- FSM states:
  - IDLE: after reset.
  - RUN: accepting input.
  - DRAIN: all 289 inputs accepted, FIFO not yet empty.
  - FIN: frame complete.
- Transitions:
  - Any state, START=1 → RUN. Clears FIFO, in_cnt, wr_cnt, CHECKSUM, OVERFLOW and DONE.
  - RUN → DRAIN when in_cnt reaches 289.
  - DRAIN → FIN when wr_cnt reaches 289.
  - A combined transition RUN → FIN is legal when the last push and last write complete together.
- Push: only in RUN, only when START=0, I_VALID=1 and in_cnt<289. Each push increments in_cnt, including a dropped push.
- Drop: a push arriving with the FIFO full and no pop in the same cycle is dropped, and OVERFLOW is set. With a pop in the same cycle, the push is accepted (simultaneous push/pop at full is legal).
- I_VALID is ignored in IDLE, DRAIN and FIN, in the START cycle, and after 289 pushes.
- Pop (write accepted): WEN=0 and W_READY=1. Each pop:
  - increments wr_cnt;
  - adds W_DATA to CHECKSUM, wrapping at 16 bits;
  - advances W_ADDR to wr_cnt+1.
- W_ADDR always equals wr_cnt. W_DATA always equals the FIFO head.
- WEN=0 iff state ∈ {RUN, DRAIN} and FIFO non-empty.
- Completion when pixels were dropped: wr_cnt can never reach 289. The FSM therefore also enters FIN when in_cnt=289 and the FIFO is empty. In that case W_ADDR stops below 289 and OVERFLOW=1.
- FIN: DONE=1 and WEN=1. DONE holds until the next START or reset.
- Reset (any time, including mid-frame): state IDLE, FIFO empty, WEN=1, W_ADDR=0, W_DATA=0, DONE=0, CHECKSUM=0, OVERFLOW=0. All outputs are held at these values until START.

## Timing
- Pointers, counters, CHECKSUM, OVERFLOW, DONE and the FSM are registered. WEN, W_ADDR and W_DATA are decoded from registers only; there is no combinational path from any input to any output.
- Latency: a push at edge n, into an empty FIFO, gives WEN=0 with that pixel on W_DATA in cycle n+1.
- W_READY=1 continuously plus a contiguous input stream gives one write per cycle and never overflows.
- The last write is accepted at edge m. wr_cnt=289 in cycle m+1. DONE=1 and WEN=1 from cycle m+2.
- START with RST_N high takes effect at the next edge. Outputs show the cleared values in the following cycle.
- RST_N low drives outputs to their reset values immediately, without waiting for a clock edge.

## Test plan
- **Nominal frame:** START, then 289 back-to-back I_VALID with I_DATA=i mod 256 and W_READY=1 → 289 writes, W_ADDR 0..288, W_DATA=i mod 256, first WEN=0 one cycle after the first I_VALID, CHECKSUM=0x8190, DONE=1, OVERFLOW=0.
- **Backpressure within capacity:** W_READY=0 for 4 cycles mid-stream → FIFO fills to 4, no drop, OVERFLOW=0, all 289 addresses written in order.
- **Overflow:** W_READY=0 for 10 cycles while input streams → 6 pixels dropped, OVERFLOW=1 sticky, DONE=1 after input ends, W_ADDR final value 283.
- **Full boundary:** FIFO full, W_READY=1, I_VALID=1 in the same cycle → push accepted, no drop, occupancy stays 4.
- **Restart mid-frame:** second START after 100 pixels → FIFO flushed, CHECKSUM=0, the next write goes to W_ADDR=0, and the full frame completes normally.
- **Async reset and post-frame input:** RST_N low mid-frame → WEN=1, W_ADDR=0, DONE=0 before the next edge. After DONE, extra I_VALID pulses cause no writes and leave CHECKSUM unchanged.
